dcache_share_arb: RTL and testbench
===================================

Name: dcache_share_arb

Overview:
- Shares the core's per-lane dcache request/response port between two requesters: req 0 = LSU demand traffic, req 1 = hardware prefetch engine.
- Sits between the LSU / prefetcher and the dcache.
- Grants whole multi-lane transactions: demand has priority, prefetch has an anti-starvation timer and a cap on outstanding responses.
- Appends a 1-bit source id as tag LSB; uses it to route responses back and strips it.

Parameters:
- NUM_LANES, 4, lanes per request (equals NUM_THREADS).
- ADDR_WIDTH, 30, word address width.
- DATA_WIDTH, 32, lane data width.
- TAG_IN_WIDTH, 8, requester tag width; output tag is TAG_IN_WIDTH+1.
- PF_MAX_WAIT, 16, cycles prefetch may wait before it is forced a grant.
- PF_MAX_PENDING, 8, maximum outstanding prefetch lane requests.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- dem_req_valid / pf_req_valid  in  NUM_LANES  per-lane request valid
- dem_req_rw / pf_req_rw  in  NUM_LANES  1 = write
- dem_req_addr / pf_req_addr  in  NUM_LANES*ADDR_WIDTH  word address
- dem_req_byteen / pf_req_byteen  in  NUM_LANES*4  byte enables
- dem_req_data / pf_req_data  in  NUM_LANES*DATA_WIDTH  write data
- dem_req_tag / pf_req_tag  in  NUM_LANES*TAG_IN_WIDTH  tag
- dem_req_ready / pf_req_ready  out  NUM_LANES  per-lane accept
- dc_req_valid, dc_req_rw, dc_req_addr, dc_req_byteen, dc_req_data  out  as above  dcache request
- dc_req_tag  out  NUM_LANES*(TAG_IN_WIDTH+1)  {tag, src}
- dc_req_ready  in  NUM_LANES  dcache accept
- dc_rsp_valid  in  1  response valid
- dc_rsp_tmask  in  NUM_LANES  response lanes
- dc_rsp_data  in  NUM_LANES*DATA_WIDTH  response data
- dc_rsp_tag  in  TAG_IN_WIDTH+1  response tag
- dc_rsp_ready  out  1  response accept
- dem_rsp_valid / pf_rsp_valid  out  1  routed response valid
- dem_rsp_tmask / pf_rsp_tmask  out  NUM_LANES  routed response lanes
- dem_rsp_data / pf_rsp_data  out  NUM_LANES*DATA_WIDTH  routed response data
- dem_rsp_tag / pf_rsp_tag  out  TAG_IN_WIDTH  tag with src bit stripped
- dem_rsp_ready / pf_rsp_ready  in  1  requester accepts response
- pf_pending  out  CLOG2(PF_MAX_PENDING+1)  outstanding prefetch lanes (debug)

Behaviour:
- State: locked (1b), gnt (1b), pf_wait counter, pf_pending counter.
- Reset (reset=0, async): all four cleared; all dc_req_valid and requester ready outputs forced 0 while reset is low.
- Requester rule: a lane's valid drops the cycle after it fires. The valid mask must not gain lanes mid-transaction.
- Unlocked, selection is combinational with zero-cycle latency:
  - pf_ok = pf_pending + NUM_LANES <= PF_MAX_PENDING.
  - If |pf_req_valid && pf_ok && (pf_wait == PF_MAX_WAIT || ~|dem_req_valid), select pf.
  - Else if |dem_req_valid, select demand.
  - Else no grant.
- Locked: selection = gnt, with no re-arbitration.
- Request forwarding:
  - dc_req_valid[i] = sel_valid[i]; payload muxed from the selected requester.
  - dc_req_tag[i] = {tag[i], src}, with src = 1 for pf.
  - Selected requester's ready[i] = dc_req_ready[i]; the other requester's ready = 0.
- Transaction end: the first cycle in which (sel_valid & ~dc_req_ready) == 0. Then locked <= 0. Otherwise locked <= 1 and gnt <= sel.
- A single-cycle full accept never sets locked.
- pf_wait:
  - Increments, saturating at PF_MAX_WAIT, each cycle pf has any valid lane and is not selected.
  - Clears on any cycle pf is selected.
  - Holds its value while pf_ok = 0.
- pf_pending: += popcount(pf lane fires where rw = 0); -= popcount(dc_rsp_tmask) on dc_rsp fire with tag src = 1. Simultaneous inc and dec apply net. Underflow is an assertion error.
- Prefetch writes are not counted; they get no response.
- Response path is combinational:
  - src = dc_rsp_tag[0]; dc_rsp_ready = src ? pf_rsp_ready : dem_rsp_ready.
  - Only the addressed requester's valid is raised.
  - The rsp tag is dc_rsp_tag[TAG_IN_WIDTH:1].

Decomposition:
- Shared package holds: SRC_DEM = 0 / SRC_PF = 1, the src-bit position constant, and the popcount function.
- One sub-module is natural: dcache_share_pf_throttle, holding the pf_wait and pf_pending counters and producing pf_ok and pf_force.

Test Plan:
- Demand-only stall: dem valid=4'b1111 with dc_req_ready=4'b0101, then 4'b1010 → two cycles, locked=1 in between; pf_req_ready stays 0; tags carry src=0.
- Contention: both requesters valid every cycle, demand always full-accept → pf is forced a grant after exactly 16 cycles waiting, and pf_wait clears.
- Throttle: pf issues two 4-lane reads (pf_pending=8) → third pf transaction blocked. One rsp with tmask=4'b1111, src=1 → pf_pending=4, next pf grant allowed.
- Simultaneous count: pf fires 2 read lanes while a pf rsp returns 3 lanes, pf_pending 5 → pf_pending 4.
- Response routing: rsp tag={0x3C,1}, pf_rsp_ready=0 → pf_rsp_valid=1, dem_rsp_valid=0, dc_rsp_ready=0, pf_rsp_tag=0x3C.
- Async reset while locked mid-transaction → dc_req_valid=0 immediately (before the next clk edge), and all counters read 0 after release.

Source files
------------

// File: rtl/dcache_share_arb_pkg.sv
// Shared definitions for the demand/prefetch dcache port arbiter.
//   SRC_DEM / SRC_PF : source id carried in the dcache tag LSB
//   SRC_BIT_POS      : bit position of the source id inside the dcache tag
//   popcount()       : number of set bits in a lane mask (masks up to 32 lanes)
package dcache_share_arb_pkg;

  localparam logic        SRC_DEM      = 1'b0;
  localparam logic        SRC_PF       = 1'b1;
  localparam int unsigned SRC_BIT_POS  = 0;
  localparam int unsigned POPCNT_MAX_W = 32;

  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCNT_MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dcache_share_pf_throttle.sv
// Prefetch throttle: anti-starvation wait counter and outstanding-read counter.
//   pf_any_valid : prefetcher presents at least one lane
//   pf_sel       : prefetcher owns the dcache port this cycle
//   pf_rd_fires  : prefetch read lanes accepted by the dcache this cycle
//   pf_rsp_lanes : prefetch response lanes consumed this cycle
//   pf_ok        : room for another full prefetch transaction
//   pf_force     : prefetch has waited the maximum and must win arbitration
//   pf_pending   : outstanding prefetch read lanes
module dcache_share_pf_throttle #(
  parameter  int unsigned NUM_LANES      = 4,
  parameter  int unsigned PF_MAX_WAIT    = 16,
  parameter  int unsigned PF_MAX_PENDING = 8,
  localparam int unsigned CNT_W          = $clog2(NUM_LANES + 1),
  localparam int unsigned PEND_W         = $clog2(PF_MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pf_any_valid,
  input  logic              pf_sel,
  input  logic [CNT_W-1:0]  pf_rd_fires,
  input  logic [CNT_W-1:0]  pf_rsp_lanes,
  output logic              pf_ok,
  output logic              pf_force,
  output logic [PEND_W-1:0] pf_pending
);

  localparam int unsigned WAIT_W = $clog2(PF_MAX_WAIT + 1);

  logic [WAIT_W-1:0] pf_wait_q, pf_wait_d;
  logic [PEND_W-1:0] pf_pending_q, pf_pending_d;
  logic [31:0]       pend_sum;

  assign pf_ok      = (32'(pf_pending_q) + NUM_LANES) <= PF_MAX_PENDING;
  assign pf_force   = pf_wait_q == WAIT_W'(PF_MAX_WAIT);
  assign pf_pending = pf_pending_q;

  // Wait counter clears on grant, freezes while throttled, else saturates upward.
  always_comb begin
    pf_wait_d = pf_wait_q;
    if (pf_sel) begin
      pf_wait_d = '0;
    end else if (pf_any_valid && pf_ok && !pf_force) begin
      pf_wait_d = pf_wait_q + WAIT_W'(1);
    end
  end

  // Issue and retire in the same cycle apply as a net change.
  always_comb begin
    pend_sum     = 32'(pf_pending_q) + 32'(pf_rd_fires);
    pf_pending_d = PEND_W'(pend_sum - 32'(pf_rsp_lanes));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_wait_q    <= '0;
      pf_pending_q <= '0;
    end else begin
      pf_wait_q    <= pf_wait_d;
      pf_pending_q <= pf_pending_d;
    end
  end

  // More prefetch responses than outstanding reads means a tag was corrupted.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (pend_sum >= 32'(pf_rsp_lanes));
    end
  end

endmodule

// File: rtl/dcache_share_arb.sv
// Shares one per-lane dcache port between LSU demand (src 0) and the
// hardware prefetcher (src 1). Whole multi-lane transactions are granted;
// demand wins unless prefetch has starved, and prefetch is throttled by its
// outstanding read count. The source id rides in the dcache tag LSB and
// steers responses back, stripped.
//   dem_req_* / pf_req_* : requester request ports (valid/ready per lane)
//   dc_req_*             : dcache request port, tag = {tag, src}
//   dc_rsp_*             : dcache response port
//   dem_rsp_* / pf_rsp_* : routed responses, src bit removed
//   pf_pending           : outstanding prefetch read lanes (debug)
module dcache_share_arb
  import dcache_share_arb_pkg::*;
#(
  parameter  int unsigned NUM_LANES      = 4,
  parameter  int unsigned ADDR_WIDTH     = 30,
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned TAG_IN_WIDTH   = 8,
  parameter  int unsigned PF_MAX_WAIT    = 16,
  parameter  int unsigned PF_MAX_PENDING = 8,
  localparam int unsigned OTW            = TAG_IN_WIDTH + 1,
  localparam int unsigned PEND_W         = $clog2(PF_MAX_PENDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_LANES-1:0]             dem_req_valid,
  input  logic [NUM_LANES-1:0]             dem_req_rw,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]  dem_req_addr,
  input  logic [NUM_LANES*4-1:0]           dem_req_byteen,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  dem_req_data,
  input  logic [NUM_LANES*TAG_IN_WIDTH-1:0] dem_req_tag,
  output logic [NUM_LANES-1:0]             dem_req_ready,
  input  logic [NUM_LANES-1:0]             pf_req_valid,
  input  logic [NUM_LANES-1:0]             pf_req_rw,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]  pf_req_addr,
  input  logic [NUM_LANES*4-1:0]           pf_req_byteen,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  pf_req_data,
  input  logic [NUM_LANES*TAG_IN_WIDTH-1:0] pf_req_tag,
  output logic [NUM_LANES-1:0]             pf_req_ready,
  output logic [NUM_LANES-1:0]             dc_req_valid,
  output logic [NUM_LANES-1:0]             dc_req_rw,
  output logic [NUM_LANES*ADDR_WIDTH-1:0]  dc_req_addr,
  output logic [NUM_LANES*4-1:0]           dc_req_byteen,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  dc_req_data,
  output logic [NUM_LANES*OTW-1:0]         dc_req_tag,
  input  logic [NUM_LANES-1:0]             dc_req_ready,
  input  logic                             dc_rsp_valid,
  input  logic [NUM_LANES-1:0]             dc_rsp_tmask,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  dc_rsp_data,
  input  logic [OTW-1:0]                   dc_rsp_tag,
  output logic                             dc_rsp_ready,
  output logic                             dem_rsp_valid,
  output logic [NUM_LANES-1:0]             dem_rsp_tmask,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  dem_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          dem_rsp_tag,
  input  logic                             dem_rsp_ready,
  output logic                             pf_rsp_valid,
  output logic [NUM_LANES-1:0]             pf_rsp_tmask,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  pf_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          pf_rsp_tag,
  input  logic                             pf_rsp_ready,
  output logic [PEND_W-1:0]                pf_pending
);

  localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

  logic locked_q, locked_d;
  logic gnt_q, gnt_d;

  logic                              sel, sel_active, arb_pf, dem_any, pf_any;
  logic [NUM_LANES-1:0]              sel_valid, fires;
  logic [NUM_LANES*TAG_IN_WIDTH-1:0] sel_tag;
  logic                              pf_ok, pf_force, stall;
  logic [CNT_W-1:0]                  pf_rd_fires, pf_rsp_lanes;
  logic                              rsp_src;

  // Grant selection: unlocked arbitration is zero-latency, locked reuses gnt.
  always_comb begin
    dem_any = |dem_req_valid;
    pf_any  = |pf_req_valid;
    arb_pf  = pf_any && pf_ok && (pf_force || !dem_any);
    if (locked_q) begin
      sel        = gnt_q;
      sel_active = 1'b1;
    end else begin
      sel        = arb_pf ? SRC_PF : SRC_DEM;
      sel_active = arb_pf || dem_any;
    end
    // Reset must silence the request side immediately, not at the next edge.
    sel_active = sel_active && reset;
  end

  // Request mux and per-lane handshake.
  always_comb begin
    sel_valid     = '0;
    dc_req_rw     = dem_req_rw;
    dc_req_addr   = dem_req_addr;
    dc_req_byteen = dem_req_byteen;
    dc_req_data   = dem_req_data;
    sel_tag       = dem_req_tag;
    dc_req_tag    = '0;
    dem_req_ready = '0;
    pf_req_ready  = '0;
    if (sel == SRC_PF) begin
      dc_req_rw     = pf_req_rw;
      dc_req_addr   = pf_req_addr;
      dc_req_byteen = pf_req_byteen;
      dc_req_data   = pf_req_data;
      sel_tag       = pf_req_tag;
    end
    if (sel_active) begin
      sel_valid = (sel == SRC_PF) ? pf_req_valid : dem_req_valid;
      if (sel == SRC_PF) pf_req_ready  = dc_req_ready;
      else               dem_req_ready = dc_req_ready;
    end
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      dc_req_tag[i*OTW +: OTW] = {sel_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH], sel};
    end
    dc_req_valid = sel_valid;
  end

  // Lock while any selected lane is still waiting on the dcache.
  always_comb begin
    fires       = sel_valid & dc_req_ready;
    stall       = |(sel_valid & ~dc_req_ready);
    locked_d    = stall;
    gnt_d       = stall ? sel : gnt_q;
    pf_rd_fires = '0;
    if (sel == SRC_PF) begin
      pf_rd_fires = CNT_W'(popcount(32'(fires & ~pf_req_rw)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked_q <= 1'b0;
      gnt_q    <= SRC_DEM;
    end else begin
      locked_q <= locked_d;
      gnt_q    <= gnt_d;
    end
  end

  // Response routing by the src bit; payload broadcast, valid steered.
  always_comb begin
    rsp_src       = dc_rsp_tag[SRC_BIT_POS];
    dc_rsp_ready  = (rsp_src == SRC_PF) ? pf_rsp_ready : dem_rsp_ready;
    dem_rsp_valid = dc_rsp_valid && (rsp_src == SRC_DEM);
    pf_rsp_valid  = dc_rsp_valid && (rsp_src == SRC_PF);
    dem_rsp_tmask = dc_rsp_tmask;
    pf_rsp_tmask  = dc_rsp_tmask;
    dem_rsp_data  = dc_rsp_data;
    pf_rsp_data   = dc_rsp_data;
    dem_rsp_tag   = dc_rsp_tag[TAG_IN_WIDTH:1];
    pf_rsp_tag    = dc_rsp_tag[TAG_IN_WIDTH:1];
    pf_rsp_lanes  = '0;
    if (pf_rsp_valid && pf_rsp_ready) begin
      pf_rsp_lanes = CNT_W'(popcount(32'(dc_rsp_tmask)));
    end
  end

  dcache_share_pf_throttle #(
    .NUM_LANES      (NUM_LANES),
    .PF_MAX_WAIT    (PF_MAX_WAIT),
    .PF_MAX_PENDING (PF_MAX_PENDING)
  ) u_throttle (
    .clk          (clk),
    .reset        (reset),
    .pf_any_valid (pf_any),
    .pf_sel       (sel_active && (sel == SRC_PF)),
    .pf_rd_fires  (pf_rd_fires),
    .pf_rsp_lanes (pf_rsp_lanes),
    .pf_ok        (pf_ok),
    .pf_force     (pf_force),
    .pf_pending   (pf_pending)
  );

endmodule

// File: tb/tb_dcache_share_arb.sv
// Scoreboard bench for dcache_share_arb: stimulus pushes the expected port
// picture for each active cycle; a negedge monitor pops and compares it
// whenever the DUT drives a dcache request or a response is presented.
module tb_dcache_share_arb;

  localparam int unsigned NL  = 4;
  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned OTW = TW + 1;
  localparam int unsigned PW  = 4;
  localparam int unsigned OBS_W = 4 + NL*OTW + NL*AW + 4 + 4 + PW + 3 + TW + NL + NL*DW;
  localparam logic [NL*DW-1:0] RSP_DATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  logic clk = 1'b0;
  logic reset;
  logic [NL-1:0]    dem_req_valid, dem_req_rw, dem_req_ready;
  logic [NL*AW-1:0] dem_req_addr;
  logic [NL*4-1:0]  dem_req_byteen;
  logic [NL*DW-1:0] dem_req_data;
  logic [NL*TW-1:0] dem_req_tag;
  logic [NL-1:0]    pf_req_valid, pf_req_rw, pf_req_ready;
  logic [NL*AW-1:0] pf_req_addr;
  logic [NL*4-1:0]  pf_req_byteen;
  logic [NL*DW-1:0] pf_req_data;
  logic [NL*TW-1:0] pf_req_tag;
  logic [NL-1:0]    dc_req_valid, dc_req_rw, dc_req_ready;
  logic [NL*AW-1:0] dc_req_addr;
  logic [NL*4-1:0]  dc_req_byteen;
  logic [NL*DW-1:0] dc_req_data;
  logic [NL*OTW-1:0] dc_req_tag;
  logic             dc_rsp_valid, dc_rsp_ready;
  logic [NL-1:0]    dc_rsp_tmask;
  logic [NL*DW-1:0] dc_rsp_data;
  logic [OTW-1:0]   dc_rsp_tag;
  logic             dem_rsp_valid, dem_rsp_ready, pf_rsp_valid, pf_rsp_ready;
  logic [NL-1:0]    dem_rsp_tmask, pf_rsp_tmask;
  logic [NL*DW-1:0] dem_rsp_data, pf_rsp_data;
  logic [TW-1:0]    dem_rsp_tag, pf_rsp_tag;
  logic [PW-1:0]    pf_pending;

  dcache_share_arb dut (
    .clk(clk), .reset(reset),
    .dem_req_valid(dem_req_valid), .dem_req_rw(dem_req_rw), .dem_req_addr(dem_req_addr),
    .dem_req_byteen(dem_req_byteen), .dem_req_data(dem_req_data), .dem_req_tag(dem_req_tag),
    .dem_req_ready(dem_req_ready),
    .pf_req_valid(pf_req_valid), .pf_req_rw(pf_req_rw), .pf_req_addr(pf_req_addr),
    .pf_req_byteen(pf_req_byteen), .pf_req_data(pf_req_data), .pf_req_tag(pf_req_tag),
    .pf_req_ready(pf_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_byteen(dc_req_byteen), .dc_req_data(dc_req_data), .dc_req_tag(dc_req_tag),
    .dc_req_ready(dc_req_ready),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_tmask(dc_rsp_tmask), .dc_rsp_data(dc_rsp_data),
    .dc_rsp_tag(dc_rsp_tag), .dc_rsp_ready(dc_rsp_ready),
    .dem_rsp_valid(dem_rsp_valid), .dem_rsp_tmask(dem_rsp_tmask), .dem_rsp_data(dem_rsp_data),
    .dem_rsp_tag(dem_rsp_tag), .dem_rsp_ready(dem_rsp_ready),
    .pf_rsp_valid(pf_rsp_valid), .pf_rsp_tmask(pf_rsp_tmask), .pf_rsp_data(pf_rsp_data),
    .pf_rsp_tag(pf_rsp_tag), .pf_rsp_ready(pf_rsp_ready),
    .pf_pending(pf_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [OBS_W-1:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Requester tag/address constants: demand 0x10+i / 0x100+i, prefetch 0x80+i / 0x200+i.
  function automatic logic [NL*OTW-1:0] exp_tag(input logic s);
    logic [NL*OTW-1:0] t;
    for (int i = 0; i < NL; i++) t[i*OTW +: OTW] = {TW'((s ? 32'h80 : 32'h10) + i), s};
    return t;
  endfunction

  function automatic logic [NL*AW-1:0] exp_addr(input logic s);
    logic [NL*AW-1:0] a;
    for (int i = 0; i < NL; i++) a[i*AW +: AW] = AW'((s ? 32'h200 : 32'h100) + i);
    return a;
  endfunction

  function automatic logic [OBS_W-1:0] obs(
      input logic [NL-1:0] dcv, input logic s, input logic [NL-1:0] demr,
      input logic [NL-1:0] pfr, input logic [PW-1:0] pend, input logic dv, input logic pv,
      input logic rr, input logic [TW-1:0] rtag, input logic [NL-1:0] rmask,
      input logic [NL*DW-1:0] rdata);
    logic [NL*OTW-1:0] t;
    logic [NL*AW-1:0]  a;
    t = (dcv != '0) ? exp_tag(s)  : '0;
    a = (dcv != '0) ? exp_addr(s) : '0;
    return {dcv, t, a, demr, pfr, pend, dv, pv, rr, rtag, rmask, rdata};
  endfunction

  task automatic push_req(input string n, input logic [NL-1:0] dcv, input logic s,
                          input logic [NL-1:0] demr, input logic [NL-1:0] pfr,
                          input logic [PW-1:0] pend);
    q.push_back('{n, obs(dcv, s, demr, pfr, pend, 1'b0, 1'b0, 1'b0, '0, '0, '0)});
  endtask

  task automatic push_rsp(input string n, input logic [NL-1:0] dcv, input logic s,
                          input logic [NL-1:0] demr, input logic [NL-1:0] pfr,
                          input logic [PW-1:0] pend, input logic dv, input logic pv,
                          input logic rr, input logic [TW-1:0] rtag, input logic [NL-1:0] rmask);
    q.push_back('{n, obs(dcv, s, demr, pfr, pend, dv, pv, rr, rtag, rmask, RSP_DATA)});
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presenting a request or a response consumes one expectation.
  always @(negedge clk) begin
    logic [OBS_W-1:0] act;
    logic [TW-1:0]    rtag;
    logic [NL-1:0]    rmask;
    logic [NL*DW-1:0] rdata;
    exp_t             e;
    if ((|dc_req_valid) || dc_rsp_valid) begin
      rtag = '0; rmask = '0; rdata = '0;
      if (pf_rsp_valid) begin
        rtag = pf_rsp_tag; rmask = pf_rsp_tmask; rdata = pf_rsp_data;
      end else if (dem_rsp_valid) begin
        rtag = dem_rsp_tag; rmask = dem_rsp_tmask; rdata = dem_rsp_data;
      end
      act = {dc_req_valid,
             (|dc_req_valid) ? dc_req_tag  : {(NL*OTW){1'b0}},
             (|dc_req_valid) ? dc_req_addr : {(NL*AW){1'b0}},
             dem_req_ready, pf_req_ready, pf_pending,
             dem_rsp_valid, pf_rsp_valid, dc_rsp_valid & dc_rsp_ready,
             rtag, rmask, rdata};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output actual=%0h expected=none", act);
      end else begin
        e = q.pop_front();
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s actual=%0h expected=%0h", e.name, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    dem_req_valid = '0; dem_req_rw = '0; pf_req_valid = '0; pf_req_rw = '0;
    dc_req_ready = '0; dc_rsp_valid = 1'b0; dc_rsp_tmask = '0; dc_rsp_tag = '0;
    dc_rsp_data = RSP_DATA; dem_rsp_ready = 1'b1; pf_rsp_ready = 1'b1;
    dem_req_byteen = '1; pf_req_byteen = '1;
    for (int i = 0; i < NL; i++) begin
      dem_req_addr[i*AW +: AW] = AW'(32'h100 + i);
      pf_req_addr[i*AW +: AW]  = AW'(32'h200 + i);
      dem_req_tag[i*TW +: TW]  = TW'(32'h10 + i);
      pf_req_tag[i*TW +: TW]   = TW'(32'h80 + i);
      dem_req_data[i*DW +: DW] = DW'(32'hD000 + i);
      pf_req_data[i*DW +: DW]  = DW'(32'hF000 + i);
    end

    // Outputs silent while reset is held, even with everything requesting.
    dem_req_valid = 4'hF; pf_req_valid = 4'hF; dc_req_ready = 4'hF;
    #7;
    chk("rst_dc_valid",  64'(dc_req_valid),  64'h0);
    chk("rst_dem_ready", 64'(dem_req_ready), 64'h0);
    chk("rst_pf_ready",  64'(pf_req_ready),  64'h0);
    chk("rst_pending",   64'(pf_pending),    64'h0);
    dem_req_valid = '0; pf_req_valid = '0; dc_req_ready = '0;
    @(posedge clk); #2 reset = 1'b1;
    step();

    // Demand-only partial accept, then completion under lock.
    step(); dem_req_valid = 4'hF; dc_req_ready = 4'b0101;
    push_req("dem_stall_first", 4'hF, 1'b0, 4'b0101, 4'h0, 4'd0);
    step(); dem_req_valid = 4'b1010; dc_req_ready = 4'b1010;
    push_req("dem_stall_second", 4'b1010, 1'b0, 4'b1010, 4'h0, 4'd0);
    step(); dem_req_valid = '0; dc_req_ready = '0;

    // Contention: prefetch forced in after 16 lost cycles, twice.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 16; k++) begin
        step(); dem_req_valid = 4'hF; pf_req_valid = 4'hF; dc_req_ready = 4'hF;
        push_req("contend_dem_wins", 4'hF, 1'b0, 4'hF, 4'h0, PW'(rep * 4));
      end
      step();
      push_req("contend_pf_forced", 4'hF, 1'b1, 4'h0, 4'hF, PW'(rep * 4));
      step(); pf_req_valid = '0;
      push_req("contend_dem_after", 4'hF, 1'b0, 4'hF, 4'h0, PW'(rep * 4 + 4));
    end

    // Throttle: 8 pending blocks a third prefetch transaction.
    step(); dem_req_valid = '0; pf_req_valid = 4'hF; dc_req_ready = 4'hF;
    #1;
    chk("thr_block_valid",   64'(dc_req_valid), 64'h0);
    chk("thr_block_pfready", 64'(pf_req_ready), 64'h0);
    chk("thr_block_pending", 64'(pf_pending),   64'd8);
    step();
    chk("thr_block_valid2",  64'(dc_req_valid), 64'h0);
    step(); dc_rsp_valid = 1'b1; dc_rsp_tmask = 4'hF; dc_rsp_tag = {8'hA5, 1'b1};
    push_rsp("thr_pf_rsp", 4'h0, 1'b0, 4'h0, 4'h0, 4'd8, 1'b0, 1'b1, 1'b1, 8'hA5, 4'hF);
    step(); dc_rsp_valid = 1'b0; pf_req_rw = 4'b1000; dc_req_ready = 4'b0001;
    push_req("thr_pf_regrant", 4'hF, 1'b1, 4'h0, 4'b0001, 4'd4);
    // Locked prefetch: two read fires and a 3-lane response in one cycle.
    step(); pf_req_valid = 4'b1110; dem_req_valid = 4'hF; dc_req_ready = 4'b0110;
    dc_rsp_valid = 1'b1; dc_rsp_tmask = 4'b0111; dc_rsp_tag = {8'h5A, 1'b1};
    push_rsp("lock_pf_net_count", 4'b1110, 1'b1, 4'h0, 4'b0110, 4'd5, 1'b0, 1'b1, 1'b1, 8'h5A, 4'b0111);
    step(); dc_rsp_valid = 1'b0; pf_req_valid = 4'b1000; dc_req_ready = 4'b1000;
    push_req("lock_pf_write_end", 4'b1000, 1'b1, 4'h0, 4'b1000, 4'd4);
    step(); pf_req_valid = '0; pf_req_rw = '0; dc_req_ready = 4'hF;
    push_req("dem_after_lock", 4'hF, 1'b0, 4'hF, 4'h0, 4'd4);
    step(); dem_req_valid = '0; dc_req_ready = '0;

    // Response routing and back-pressure.
    step(); dc_rsp_valid = 1'b1; dc_rsp_tmask = 4'hF; dc_rsp_tag = {8'h3C, 1'b1}; pf_rsp_ready = 1'b0;
    push_rsp("route_pf_hold", 4'h0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0, 8'h3C, 4'hF);
    step(); pf_rsp_ready = 1'b1;
    push_rsp("route_pf_fire", 4'h0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b1, 1'b1, 8'h3C, 4'hF);
    step(); dc_rsp_tag = {8'h55, 1'b0}; dc_rsp_tmask = 4'b0011;
    push_rsp("route_dem_fire", 4'h0, 1'b0, 4'h0, 4'h0, 4'd0, 1'b1, 1'b0, 1'b1, 8'h55, 4'b0011);
    step(); dem_rsp_ready = 1'b0;
    push_rsp("route_dem_hold", 4'h0, 1'b0, 4'h0, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h55, 4'b0011);
    step(); dc_rsp_valid = 1'b0; dem_rsp_ready = 1'b1;

    // Async reset while a prefetch transaction is locked.
    step(); pf_req_valid = 4'hF; dc_req_ready = 4'b0011;
    push_req("rst_pre_lock", 4'hF, 1'b1, 4'h0, 4'b0011, 4'd0);
    step(); pf_req_valid = 4'b1100; dem_req_valid = 4'hF; dc_req_ready = 4'h0;
    #1;
    chk("pre_rst_locked_valid", 64'(dc_req_valid), 64'hC);
    chk("pre_rst_pending",      64'(pf_pending),   64'd2);
    reset = 1'b0;
    #1;
    chk("async_rst_valid",     64'(dc_req_valid),  64'h0);
    chk("async_rst_dem_ready", 64'(dem_req_ready), 64'h0);
    chk("async_rst_pf_ready",  64'(pf_req_ready),  64'h0);
    chk("async_rst_pending",   64'(pf_pending),    64'h0);
    step(); reset = 1'b1; pf_req_valid = '0; dc_req_ready = 4'hF;
    push_req("post_rst_unlocked_dem", 4'hF, 1'b0, 4'hF, 4'h0, 4'd0);
    step(); dem_req_valid = '0; dc_req_ready = '0;
    step();
    step();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
